// File: rtl/linear_embed_pkg.sv
// linear_embed_pkg: shared FSM state type, default sizing and the round/saturate helper.
package linear_embed_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_PATCH_DEF = 15;
  localparam int D_MODEL_DEF = 16;
  localparam int DW_DEF      = 8;
  localparam int FRAC_DEF    = 4;

  // Wide working width; covers 2*DW+1 bits for any DW up to 31.
  localparam int ACC_W = 64;

  typedef struct packed {
    logic                    sat;
    logic signed [ACC_W-1:0] data;
  } sat_res_t;

  // Round half up at bit FRAC, add bias, clamp to the signed dw-bit range.
  // The result is sign-extended to ACC_W bits; sat flags a clamp.
  function automatic sat_res_t sat_round(
    input logic signed [ACC_W-1:0] prod,
    input logic signed [ACC_W-1:0] bias,
    input int unsigned             dw,
    input int unsigned             frac
  );
    logic signed [ACC_W-1:0] half_v;
    logic signed [ACC_W-1:0] rnd_v;
    logic signed [ACC_W-1:0] sum_v;
    logic signed [ACC_W-1:0] max_v;
    logic signed [ACC_W-1:0] min_v;
    sat_res_t                res;
    half_v = 64'sd1 <<< (frac - 32'd1);
    rnd_v  = (prod + half_v) >>> frac;
    sum_v  = rnd_v + bias;
    max_v  = (64'sd1 <<< (dw - 32'd1)) - 64'sd1;
    min_v  = -(64'sd1 <<< (dw - 32'd1));
    if (sum_v > max_v) begin
      res.sat  = 1'b1;
      res.data = max_v;
    end else if (sum_v < min_v) begin
      res.sat  = 1'b1;
      res.data = min_v;
    end else begin
      res.sat  = 1'b0;
      res.data = sum_v;
    end
    return res;
  endfunction

endpackage

// File: rtl/embed_mac_sat.sv
// embed_mac_sat: combinational x*wt, round half up, bias add and clamp for one element.
module embed_mac_sat
  import linear_embed_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] wt,
  input  logic signed [DW-1:0] bias,
  output logic signed [DW-1:0] data,
  output logic                 sat
);

  logic signed [2*DW-1:0] prod_s;
  sat_res_t               res_s;
  logic                   unused_hi_s;

  // Full-precision product, then the shared round/saturate helper.
  always_comb begin
    prod_s      = x * wt;
    res_s       = sat_round(64'(prod_s), 64'(bias), DW, FRAC);
    data        = res_s.data[DW-1:0];
    sat         = res_s.sat;
    unused_hi_s = ^res_s.data[ACC_W-1:DW];
  end

endmodule

// File: rtl/linear_embed_stream.sv
// linear_embed_stream: streams sat(round(x[p]*wt[c]) + bias[c]) row by row,
// with the class token inserted as an extra row, over a valid/ready link.
module linear_embed_stream
  import linear_embed_pkg::*;
#(
  parameter int N_PATCH   = N_PATCH_DEF,
  parameter int D_MODEL   = D_MODEL_DEF,
  parameter int DW        = DW_DEF,
  parameter int FRAC      = FRAC_DEF,
  parameter int CLS_FIRST = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic signed [DW-1:0]               x_in      [N_PATCH],
  input  logic signed [DW-1:0]               wt        [D_MODEL],
  input  logic signed [DW-1:0]               bias      [D_MODEL],
  input  logic signed [DW-1:0]               cls_token [D_MODEL],
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic signed [DW-1:0]               out_data,
  output logic [$clog2(N_PATCH+1)-1:0]       out_row,
  output logic [$clog2(D_MODEL)-1:0]         out_col,
  output logic                               busy,
  output logic                               done,
  output logic                               sat_flag
);

  localparam int RW = $clog2(N_PATCH + 1);
  localparam int CW = $clog2(D_MODEL);

  state_t               state_r, state_nx_s;
  logic signed [DW-1:0] x_r   [N_PATCH];
  logic signed [DW-1:0] wt_r  [D_MODEL];
  logic signed [DW-1:0] bias_r[D_MODEL];
  logic signed [DW-1:0] cls_r [D_MODEL];

  // (row_r, col_r) points at the next element to load into the output register.
  logic [RW-1:0]        row_r;
  logic [CW-1:0]        col_r;
  logic                 issued_all_r;

  logic                 out_valid_r;
  logic signed [DW-1:0] out_data_r;
  logic [RW-1:0]        out_row_r;
  logic [CW-1:0]        out_col_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 sat_r;

  logic                 can_load_s;
  logic                 take_s;
  logic                 drop_s;
  logic                 live_s;
  logic                 is_cls_s;
  logic [RW-1:0]        pidx_s;
  logic                 last_col_s;
  logic                 last_elem_s;
  logic signed [DW-1:0] x_sel_s;
  logic signed [DW-1:0] w_sel_s;
  logic signed [DW-1:0] b_sel_s;
  logic signed [DW-1:0] c_sel_s;
  logic signed [DW-1:0] mac_data_s;
  logic                 mac_sat_s;
  logic signed [DW-1:0] elem_data_s;
  logic                 elem_sat_s;

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_row   = out_row_r;
  assign out_col   = out_col_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign sat_flag  = sat_r;

  assign can_load_s = ~out_valid_r | out_ready;

  // Next-state and load/drop strobes for the output register.
  always_comb begin
    state_nx_s = state_r;
    take_s     = 1'b0;
    drop_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = RUN;
          take_s     = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (can_load_s && issued_all_r) begin
          drop_s     = 1'b1;
          state_nx_s = DONE;
        end else if (can_load_s) begin
          take_s     = 1'b1;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Element selection; in IDLE the first element comes straight from the
  // live inputs so it can be presented one cycle after start.
  always_comb begin
    live_s      = (state_r == IDLE);
    if (CLS_FIRST != 0) begin
      is_cls_s = (row_r == RW'(0));
      pidx_s   = is_cls_s ? RW'(0) : (row_r - RW'(1));
    end else begin
      is_cls_s = (row_r == RW'(N_PATCH));
      pidx_s   = row_r;
    end
    last_col_s  = (col_r == CW'(D_MODEL - 1));
    last_elem_s = last_col_s && (row_r == RW'(N_PATCH));
    x_sel_s     = '0;
    for (int i = 0; i < N_PATCH; i++) begin
      if (pidx_s == RW'(i)) begin
        x_sel_s = live_s ? x_in[i] : x_r[i];
      end else begin
        x_sel_s = x_sel_s;
      end
    end
    if (live_s) begin
      w_sel_s = wt[col_r];
      b_sel_s = bias[col_r];
      c_sel_s = cls_token[col_r];
    end else begin
      w_sel_s = wt_r[col_r];
      b_sel_s = bias_r[col_r];
      c_sel_s = cls_r[col_r];
    end
    if (is_cls_s) begin
      elem_data_s = c_sel_s;
      elem_sat_s  = 1'b0;
    end else begin
      elem_data_s = mac_data_s;
      elem_sat_s  = mac_sat_s;
    end
  end

  embed_mac_sat #(
    .DW   (DW),
    .FRAC (FRAC)
  ) u_mac (
    .x    (x_sel_s),
    .wt   (w_sel_s),
    .bias (b_sel_s),
    .data (mac_data_s),
    .sat  (mac_sat_s)
  );

  // FSM state plus busy/done status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != IDLE);
      done_r  <= (state_nx_s == DONE);
    end
  end

  // Operand latches, captured only when a pass is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PATCH; i++) x_r[i] <= '0;
      for (int i = 0; i < D_MODEL; i++) begin
        wt_r[i]   <= '0;
        bias_r[i] <= '0;
        cls_r[i]  <= '0;
      end
    end else if (state_r == IDLE && start) begin
      x_r    <= x_in;
      wt_r   <= wt;
      bias_r <= bias;
      cls_r  <= cls_token;
    end
  end

  // Row-major element pointer; parks at the last element once it is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_r        <= '0;
      col_r        <= '0;
      issued_all_r <= 1'b0;
    end else if (take_s) begin
      if (last_elem_s) begin
        issued_all_r <= 1'b1;
      end else if (last_col_s) begin
        col_r <= '0;
        row_r <= row_r + RW'(1);
      end else begin
        col_r <= col_r + CW'(1);
      end
    end else if (state_nx_s != RUN) begin
      row_r        <= '0;
      col_r        <= '0;
      issued_all_r <= 1'b0;
    end
  end

  // Output element register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_row_r   <= '0;
      out_col_r   <= '0;
    end else if (take_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= elem_data_s;
      out_row_r   <= row_r;
      out_col_r   <= col_r;
    end else if (drop_s) begin
      out_valid_r <= 1'b0;
    end
  end

  // Sticky saturation flag; restarts from the first element of a new pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_r <= 1'b0;
    end else if (take_s && state_r == IDLE) begin
      sat_r <= elem_sat_s;
    end else if (take_s) begin
      sat_r <= sat_r | elem_sat_s;
    end
  end

endmodule

// File: tb/tb_linear_embed_stream.sv
// tb_linear_embed_stream: directed-vector bench for the default (CLS last)
// configuration and a small CLS-first configuration.
module tb_linear_embed_stream;

  logic clk;
  logic rst_n;

  logic              start_a, ready_a, valid_a, busy_a, done_a, sat_a;
  logic signed [7:0] x_a[15], w_a[16], b_a[16], c_a[16];
  logic signed [7:0] data_a;
  logic [3:0]        row_a, col_a;

  logic              start_b, ready_b, valid_b, busy_b, done_b, sat_b;
  logic signed [7:0] x_b[4], w_b[8], b_b[8], c_b[8];
  logic signed [7:0] data_b;
  logic [2:0]        row_b, col_b;

  int errors_n;
  int checks_n;
  int mx[16], mw[16], mb[16], mc[16];

  linear_embed_stream #(.N_PATCH(15), .D_MODEL(16), .DW(8), .FRAC(4), .CLS_FIRST(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .x_in(x_a), .wt(w_a), .bias(b_a),
    .cls_token(c_a), .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a),
    .out_row(row_a), .out_col(col_a), .busy(busy_a), .done(done_a), .sat_flag(sat_a)
  );

  linear_embed_stream #(.N_PATCH(4), .D_MODEL(8), .DW(8), .FRAC(4), .CLS_FIRST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .x_in(x_b), .wt(w_b), .bias(b_b),
    .cls_token(c_b), .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b),
    .out_row(row_b), .out_col(col_b), .busy(busy_b), .done(done_b), .sat_flag(sat_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      errors_n++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference element: integer floor division for the half-up rounding.
  function automatic void model(input int inst, input int beat, output int d,
                                output bit s, output int r, output int c);
    int dm, np, p, t, q, sum;
    bit cf;
    dm = (inst == 1) ? 8 : 16;
    np = (inst == 1) ? 4 : 15;
    cf = (inst == 1);
    r  = beat / dm;
    c  = beat % dm;
    s  = 1'b0;
    if ((cf && r == 0) || (!cf && r == np)) begin
      d = mc[c];
    end else begin
      p = cf ? r - 1 : r;
      t = mx[p] * mw[c] + 8;
      q = t / 16;
      if ((t % 16 != 0) && (t < 0)) q = q - 1;
      sum = q + mb[c];
      if (sum > 127) begin d = 127; s = 1'b1; end
      else if (sum < -128) begin d = -128; s = 1'b1; end
      else d = sum;
    end
  endfunction

  function automatic void sample(input int inst, output logic signed [31:0] v, d, r, c,
                                 dn, bs, st);
    v  = inst ? 32'(valid_b) : 32'(valid_a);
    d  = inst ? 32'(data_b)  : 32'(data_a);
    r  = inst ? 32'(row_b)   : 32'(row_a);
    c  = inst ? 32'(col_b)   : 32'(col_a);
    dn = inst ? 32'(done_b)  : 32'(done_a);
    bs = inst ? 32'(busy_b)  : 32'(busy_a);
    st = inst ? 32'(sat_b)   : 32'(sat_a);
  endfunction

  task automatic set_uniform(input int xv, input int wv, input int bv);
    for (int i = 0; i < 16; i++) begin
      mx[i] = xv; mw[i] = wv; mb[i] = bv; mc[i] = i * 9 - 70;
    end
  endtask

  task automatic set_pattern();
    for (int i = 0; i < 16; i++) begin
      mx[i] = ((i * 53 + 17) % 256) - 128;
      mw[i] = ((i * 29 + 101) % 256) - 128;
      mb[i] = ((i * 71 + 5) % 256) - 128;
      mc[i] = 60 - i * 11;
    end
  endtask

  task automatic push_inputs();
    for (int i = 0; i < 15; i++) x_a[i] = 8'(mx[i]);
    for (int i = 0; i < 16; i++) begin w_a[i] = 8'(mw[i]); b_a[i] = 8'(mb[i]); c_a[i] = 8'(mc[i]); end
    for (int i = 0; i < 4; i++) x_b[i] = 8'(mx[i]);
    for (int i = 0; i < 8; i++) begin w_b[i] = 8'(mw[i]); b_b[i] = 8'(mb[i]); c_b[i] = 8'(mc[i]); end
  endtask

  // Changes the DUT-facing operands after start; a pass must ignore these.
  task automatic scramble_inputs();
    for (int i = 0; i < 15; i++) x_a[i] = 8'sh3c;
    for (int i = 0; i < 16; i++) begin w_a[i] = 8'sh5a; b_a[i] = -8'sd33; c_a[i] = 8'sh11; end
    for (int i = 0; i < 4; i++) x_b[i] = 8'sh3c;
    for (int i = 0; i < 8; i++) begin w_b[i] = 8'sh5a; b_b[i] = -8'sd33; c_b[i] = 8'sh11; end
  endtask

  // mode 0: always ready; mode 1: 3-cycle stall at element 5, random stalls after.
  // abort_at > 0 returns mid-pass once that many beats have been accepted.
  task automatic run_pass(input int inst, input int mode, input int abort_at);
    int total, beat, cyc, stall_left, ed, er, ec;
    bit did5, satacc, es, rdy, stalled;
    logic signed [31:0] v, d, r, c, dn, bs, st, pv_d, pv_r, pv_c;
    total = inst ? 40 : 256;
    beat = 0; cyc = 0; stall_left = 0; did5 = 0; satacc = 0; stalled = 0;
    pv_d = 0; pv_r = 0; pv_c = 0;
    push_inputs();
    @(negedge clk);
    if (inst == 1) begin start_b = 1'b1; ready_b = 1'b1; end
    else begin start_a = 1'b1; ready_a = 1'b1; end
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    scramble_inputs();
    while (beat < total && cyc < 4 * total + 50 && !(abort_at > 0 && beat == abort_at)) begin
      sample(inst, v, d, r, c, dn, bs, st);
      model(inst, beat, ed, es, er, ec);
      satacc = satacc | es;
      chk_val("valid", v, 1);
      chk_val("data", d, ed);
      chk_val("row", r, er);
      chk_val("col", c, ec);
      chk_val("busy_run", bs, 1);
      chk_val("done_early", dn, 0);
      chk_val("sat_run", st, 32'(satacc));
      if (stalled) begin
        chk_val("hold_data", d, pv_d);
        chk_val("hold_row", r, pv_r);
        chk_val("hold_col", c, pv_c);
      end
      if (inst == 1) start_b = (cyc == 10);
      if (mode == 1 && beat == 5 && !did5) begin stall_left = 3; did5 = 1'b1; end
      if (stall_left > 0) begin rdy = 1'b0; stall_left--; end
      else if (mode == 1 && beat > 5) rdy = ($urandom_range(3, 0) != 0);
      else rdy = 1'b1;
      if (inst == 1) ready_b = rdy; else ready_a = rdy;
      stalled = !rdy;
      pv_d = d; pv_r = r; pv_c = c;
      if (v == 1 && rdy) beat++;
      cyc++;
      @(negedge clk);
    end
    start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
    if (abort_at > 0 && beat == abort_at) return;
    if (beat < total) begin
      chk_val("timeout_beats", beat, total);
    end else begin
      sample(inst, v, d, r, c, dn, bs, st);
      chk_val("done_pulse", dn, 1);
      chk_val("valid_end", v, 0);
      chk_val("busy_in_done", bs, 1);
      chk_val("sat_end", st, 32'(satacc));
      @(negedge clk);
      sample(inst, v, d, r, c, dn, bs, st);
      chk_val("done_once", dn, 0);
      chk_val("busy_idle", bs, 0);
      chk_val("sat_hold", st, 32'(satacc));
    end
  endtask

  initial begin
    logic signed [31:0] v, d, r, c, dn, bs, st;
    errors_n = 0; checks_n = 0;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
    set_uniform(0, 0, 0);
    push_inputs();
    repeat (3) @(negedge clk);
    sample(0, v, d, r, c, dn, bs, st);
    chk_val("rst_valid", v, 0); chk_val("rst_data", d, 0); chk_val("rst_row", r, 0);
    chk_val("rst_col", c, 0); chk_val("rst_done", dn, 0); chk_val("rst_busy", bs, 0);
    chk_val("rst_sat", st, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    set_uniform(16, 32, 8);    run_pass(0, 0, 0);   // 1.0*2.0+0.5 -> 0x28
    set_uniform(112, 112, 16); run_pass(0, 0, 0);   // clamps to 0x7F
    set_uniform(-128, 112, 16); run_pass(0, 0, 0);  // clamps to 0x80
    set_uniform(1, 8, 0);      run_pass(0, 0, 0);   // rounds up to 0x01, sat cleared
    set_uniform(-16, 32, 0);   run_pass(0, 0, 0);   // 0xE0
    set_pattern();             run_pass(0, 1, 0);   // backpressure, mixed operands
    set_pattern();             run_pass(1, 0, 0);   // CLS first, mid-pass start ignored
    set_uniform(-16, 32, 8);   run_pass(1, 1, 0);

    // Reset in the middle of a saturating pass.
    set_uniform(112, 112, 16); run_pass(0, 0, 100);
    #3 rst_n = 1'b0;
    #1;
    sample(0, v, d, r, c, dn, bs, st);
    chk_val("abort_valid", v, 0); chk_val("abort_busy", bs, 0);
    chk_val("abort_done", dn, 0); chk_val("abort_sat", st, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      sample(0, v, d, r, c, dn, bs, st);
      chk_val("post_rst_valid", v, 0); chk_val("post_rst_done", dn, 0);
      chk_val("post_rst_busy", bs, 0);
    end
    set_uniform(16, 32, 8);    run_pass(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors_n, checks_n);
    $finish;
  end

endmodule
